// File: rtl/exec_controller.sv
// Execution controller: step/burst/run sessions, PC breakpoints and stop-cause reporting.
// Optional run watchdog enabled by defining EXEC_CTRL_WATCHDOG_EN.
module exec_controller #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_BP   = 4,
    parameter int unsigned WDOG_CYC = 1048576
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            grant_i,
    input  logic            exec_mode_i,
    output logic            done_o,
    input  logic [7:0]      rx_data_i,
    input  logic            rx_ready_i,
    input  logic            core_halted_i,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_pc_i,
    output logic            cpu_stall_o,
    output logic            cpu_reset_o,
    output logic            dump_trigger_o,
    output logic            dump_mem_mode_o,
    input  logic            dump_done_i,
    output logic [1:0]      stop_cause_o,
    output logic [3:0]      bp_hit_idx_o
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned BP_AW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    localparam logic [7:0] CMD_STEP   = 8'hAE;
    localparam logic [7:0] CMD_BURST  = 8'hA7;
    localparam logic [7:0] CMD_RUN    = 8'hAC;
    localparam logic [7:0] CMD_BP_SET = 8'hB1;
    localparam logic [7:0] CMD_BP_CLR = 8'hB2;

    localparam logic [1:0] CAUSE_STEP = 2'b00;
    localparam logic [1:0] CAUSE_HALT = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_WDOG = 2'b11;

    typedef enum logic [3:0] {
        IDLE, WAIT_CMD, GET_ARG, STEP, RUN, TRIG_DUMP, WAIT_DUMP, CHECK, EXIT
    } state_t;

    state_t            state;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        cmd_q;
    logic [2:0]        arg_cnt_q;
    logic [7:0]        arg_idx_q;
    logic [31:0]       arg_addr_q;
    logic [XLEN-1:0]   bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q;

    logic              bp_hit_c;
    logic [IDX_W-1:0]  bp_idx_c;
    logic              wdog_hit_c;
    logic              stop_c;
    logic [1:0]        cause_c;

    assign cpu_reset_o = 1'b0;

    // Breakpoint compare; scanning downwards leaves the lowest matching slot.
    always_comb begin
        bp_hit_c = 1'b0;
        bp_idx_c = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (wb_valid_i && bp_en_q[i] && (bp_addr_q[i] == wb_pc_i)) begin
                bp_hit_c = 1'b1;
                bp_idx_c = IDX_W'(i);
            end
        end
    end

`ifdef EXEC_CTRL_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_q;

    assign wdog_hit_c = (state == RUN) && (wdog_q == WDOG_W'(WDOG_CYC - 1));

    // Counts unstalled RUN cycles; leaving RUN restarts the budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else if (state != RUN) begin
            wdog_q <= '0;
        end else if (!wdog_hit_c) begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end
`else
    assign wdog_hit_c = 1'b0;
`endif

    assign stop_c  = core_halted_i | bp_hit_c | wdog_hit_c;
    assign cause_c = core_halted_i ? CAUSE_HALT : (bp_hit_c ? CAUSE_BP : CAUSE_WDOG);

    // State change with its registered outputs decoded from the destination state.
    task automatic go(input state_t s);
        state          <= s;
        cpu_stall_o    <= !((s == STEP) || (s == RUN));
        dump_trigger_o <= (s == TRIG_DUMP);
        done_o         <= (s == EXIT);
    endtask

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            cpu_stall_o     <= 1'b1;
            dump_trigger_o  <= 1'b0;
            done_o          <= 1'b0;
            dump_mem_mode_o <= 1'b0;
            stop_cause_o    <= CAUSE_STEP;
            bp_hit_idx_o    <= '0;
            mode_q          <= 1'b0;
            cnt_q           <= '0;
            cmd_q           <= '0;
            arg_cnt_q       <= '0;
            arg_idx_q       <= '0;
            arg_addr_q      <= '0;
            bp_en_q         <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) bp_addr_q[i] <= '0;
        end else begin
            go(state);
            case (state)
                IDLE: if (grant_i) begin
                    mode_q          <= exec_mode_i;
                    dump_mem_mode_o <= exec_mode_i;
                    stop_cause_o    <= CAUSE_STEP;
                    bp_hit_idx_o    <= '0;
                    go(exec_mode_i ? RUN : WAIT_CMD);
                end
                WAIT_CMD: if (rx_ready_i) begin
                    cmd_q     <= rx_data_i;
                    arg_cnt_q <= '0;
                    case (rx_data_i)
                        CMD_STEP: begin
                            cnt_q <= CNT_W'(1);
                            go(STEP);
                        end
                        CMD_BURST, CMD_BP_SET, CMD_BP_CLR: go(GET_ARG);
                        CMD_RUN: go(RUN);
                        default: ;
                    endcase
                end
                GET_ARG: if (rx_ready_i) begin
                    arg_cnt_q  <= arg_cnt_q + 3'd1;
                    arg_addr_q <= {rx_data_i, arg_addr_q[31:8]};
                    if (arg_cnt_q == 3'd0) arg_idx_q <= rx_data_i;
                    case (cmd_q)
                        CMD_BURST: begin
                            cnt_q <= (rx_data_i == 8'd0) ? CNT_W'(256) : CNT_W'(rx_data_i);
                            go(STEP);
                        end
                        CMD_BP_CLR: begin
                            if (32'(rx_data_i) < NUM_BP) bp_en_q[rx_data_i[BP_AW-1:0]] <= 1'b0;
                            go(WAIT_CMD);
                        end
                        default: if (arg_cnt_q == 3'd4) begin
                            // Index byte first, then address bytes LSB first.
                            if (32'(arg_idx_q) < NUM_BP) begin
                                bp_addr_q[arg_idx_q[BP_AW-1:0]] <= XLEN'({rx_data_i, arg_addr_q[31:8]});
                                bp_en_q[arg_idx_q[BP_AW-1:0]]   <= 1'b1;
                            end
                            go(WAIT_CMD);
                        end
                    endcase
                end
                STEP: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (stop_c) begin
                        stop_cause_o <= cause_c;
                        bp_hit_idx_o <= (cause_c == CAUSE_BP) ? bp_idx_c : '0;
                        go(TRIG_DUMP);
                    end else if (cnt_q <= CNT_W'(1)) begin
                        stop_cause_o <= CAUSE_STEP;
                        go(TRIG_DUMP);
                    end
                end
                RUN: if (stop_c) begin
                    stop_cause_o <= cause_c;
                    bp_hit_idx_o <= (cause_c == CAUSE_BP) ? bp_idx_c : '0;
                    go(TRIG_DUMP);
                end
                TRIG_DUMP: go(WAIT_DUMP);
                WAIT_DUMP: if (dump_done_i) begin
                    if ((stop_cause_o == CAUSE_HALT) || (stop_cause_o == CAUSE_WDOG) || mode_q)
                        go(EXIT);
                    else
                        go(CHECK);
                end
                CHECK: go(core_halted_i ? EXIT : WAIT_CMD);
                EXIT: if (!grant_i) go(IDLE);
                default: go(IDLE);
            endcase
            // Losing the grant mid-session abandons it with the core frozen.
            if (!grant_i && (state != IDLE) && (state != EXIT)) go(IDLE);
        end
    end

endmodule
